bcd_frame_loader: RTL and testbench
===================================

Name: bcd_frame_loader

Overview:
- Writer side of the 4-digit display datapath.
- Accepts a serial stream of BCD digits over a valid/ready handshake, most-significant digit first.
- Assembles 4 digits into a shadow frame, then commits all four to the units/tens/hundreds/thousands buses in one cycle; the display digit-select mux reads those buses.
- Validates each digit, aborts stale partial frames by timeout, and reports completed and errored frames.

Parameters:
- TIMEOUT_CYCLES, 1000000: idle cycles allowed between accepted digits of a partial frame before abort; minimum 2.
- RESET_DIGIT, 0: value (0-9) loaded into all four output digits at reset.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_digit is valid this cycle
- in_digit  input  4  BCD digit, MSD first (thousands, hundreds, tens, units)
- in_sof  input  1  start of frame; qualified by in_valid
- in_ready  output  1  loader can accept a digit this cycle
- err_clr  input  1  clears ERROR state and err flag
- thousands  output  4  committed digit 3
- hundreds  output  4  committed digit 2
- tens  output  4  committed digit 1
- units  output  4  committed digit 0
- frame_done  output  1  one-cycle pulse; outputs updated this cycle
- err  output  1  sticky error flag
- err_code  output  2  01 = digit > 9, 10 = timeout, 11 = SOF mid-frame; 00 = none

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high on rst.
- Reset values: all digit outputs = RESET_DIGIT; frame_done = 0; err = 0; err_code = 00; state IDLE; digit index = 0; timeout counter = 0.
- Transfer: a transfer occurs on a rising edge where in_valid & in_ready. in_ready is 1 in IDLE and COLLECT, and 0 in COMMIT and ERROR. in_ready is registered state only and is not combinationally dependent on in_valid.
- IDLE:
  - A transfer with in_sof = 1 and digit ≤ 9 stores the digit in shadow[3], sets index = 1, and goes to COLLECT.
  - A transfer with in_sof = 0 is dropped silently and raises no error.
  - A transfer with in_sof = 1 and digit > 9 goes to ERROR with code 01.
- COLLECT:
  - A transfer with digit ≤ 9 and in_sof = 0 stores the digit in shadow[3-index] and increments index.
  - When index reaches 4 (4th digit accepted), go to COMMIT.
  - digit > 9 goes to ERROR with code 01. in_sof = 1 goes to ERROR with code 11, and the digit is discarded.
  - If digit > 9 and in_sof = 1 occur together, code 01 takes priority.
- Timeout: the counter resets on every transfer and increments every cycle in COLLECT without a transfer. When it reaches TIMEOUT_CYCLES, go to ERROR with code 10.
- COMMIT (exactly 1 cycle): copy shadow[3:0] to thousands/hundreds/tens/units, pulse frame_done, return to IDLE.
  - Latency: outputs change on the clock edge after the 4th digit's transfer edge; frame_done is high in that same cycle.
- ERROR:
  - err = 1 and err_code holds the value. Shadow is discarded and committed outputs are unchanged.
  - err_clr = 1 gives err = 0, code 00, index 0, state IDLE on the next edge.
  - err_clr in any other state has no effect.
- Invariant: committed outputs change only in COMMIT. A partial or aborted frame never reaches the outputs.
- Reset mid-frame: a partial frame is discarded and the outputs return to RESET_DIGIT.
- Back-to-back frames: a new SOF is accepted in the cycle after COMMIT, giving a sustained rate of 4 digits per 5 cycles.

Optional Feature:
- Macro: BCD_LEADING_ZERO_BLANK_EN.
- Defined: at COMMIT, leading zero digits from thousands down are written as 4'hF (blank code for the decoder). units is never blanked; frame 0,0,0,0 commits as F,F,F,0 and frame 0,1,0,0 commits as F,1,0,0.
- Undefined: digits are committed verbatim and no blanking logic is synthesized.

Test Plan:
- Reset, then stream SOF+1, 2, 3, 4 with in_valid held high -> in_ready low 1 cycle; thousands=1 hundreds=2 tens=3 units=4; frame_done high one cycle, 1 cycle after the 4th transfer.
- Stream 7, 8 (in_sof=0) while IDLE -> dropped; outputs keep RESET_DIGIT; no frame_done; err=0.
- SOF+5, 6, then digit 4'hA -> err=1, err_code=01, in_ready=0, outputs unchanged; err_clr -> err=0, in_ready=1; full frame 9,8,7,6 then commits correctly.
- TIMEOUT_CYCLES=16: SOF+3, then no valid for 16 cycles -> err_code=10; outputs unchanged.
- SOF+1, 2, then SOF+4 -> err_code=11; rst asserted mid-frame in a second run -> outputs = RESET_DIGIT, state IDLE.
- With BCD_LEADING_ZERO_BLANK_EN: frame 0,0,4,2 -> thousands=F, hundreds=F, tens=4, units=2; frame 0,0,0,0 -> F,F,F,0.

Source files
------------

// File: rtl/bcd_frame_loader.sv
// bcd_frame_loader: writer side of the 4-digit display datapath.
// Collects four BCD digits (MSD first) over valid/ready into a shadow frame and
// commits them to the thousands/hundreds/tens/units buses in a single cycle.
// Optional macro BCD_LEADING_ZERO_BLANK_EN: leading zeros (thousands down to tens)
// are committed as 4'hF so the decoder blanks them; units is never blanked.
//
// state   | meaning
// IDLE    | waiting for an SOF digit; non-SOF digits are dropped
// COLLECT | frame in progress, index = next shadow slot, timeout running
// COMMIT  | one cycle: shadow copied to outputs, frame_done pulsed
// ERROR   | sticky error held until err_clr
module bcd_frame_loader #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int RESET_DIGIT    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_digit,
    input  logic       in_sof,
    output logic       in_ready,
    input  logic       err_clr,
    output logic [3:0] thousands,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       frame_done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int            TW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RST_D   = 4'(RESET_DIGIT);

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT, ERROR} state_t;

    state_t               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [3:0][3:0]      shadow_q, shadow_d;
    logic [3:0][3:0]      frame_q, frame_d;
    logic [3:0][3:0]      commit_val;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [1:0]           code_q, code_d;
    logic                 xfer;
    logic                 bad_digit;

    // Ready is a decode of the state register only, never of in_valid.
    assign in_ready  = (state_q == IDLE) || (state_q == COLLECT);
    assign xfer      = in_valid & in_ready;
    assign bad_digit = in_digit > 4'd9;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic blank3, blank2, blank1;
    assign blank3 = (shadow_q[3] == 4'd0);
    assign blank2 = blank3 & (shadow_q[2] == 4'd0);
    assign blank1 = blank2 & (shadow_q[1] == 4'd0);
    assign commit_val = {blank3 ? 4'hF : shadow_q[3],
                         blank2 ? 4'hF : shadow_q[2],
                         blank1 ? 4'hF : shadow_q[1],
                         shadow_q[0]};
`else
    assign commit_val = shadow_q;
`endif

    // Next-state and next-output logic for the frame FSM.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tcnt_d   = tcnt_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        done_d   = 1'b0;
        err_d    = err_q;
        code_d   = code_q;
        case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (xfer && in_sof) begin
                    if (bad_digit) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                    end else begin
                        shadow_d[3] = in_digit;
                        idx_d       = 2'd1;
                        state_d     = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (xfer) begin
                    tcnt_d = '0;
                    // Bad digit outranks a stray SOF when both arrive together.
                    if (bad_digit) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                        idx_d   = 2'd0;
                    end else if (in_sof) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                        code_d  = 2'b11;
                        idx_d   = 2'd0;
                    end else begin
                        shadow_d[2'd3 - idx_q] = in_digit;
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) state_d = COMMIT;
                    end
                end else if (tcnt_q == TC_LAST) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                    code_d  = 2'b10;
                    idx_d   = 2'd0;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            COMMIT: begin
                frame_d = commit_val;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            ERROR: begin
                if (err_clr) begin
                    err_d   = 1'b0;
                    code_d  = 2'b00;
                    idx_d   = 2'd0;
                    tcnt_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            tcnt_q   <= '0;
            shadow_q <= '0;
            frame_q  <= {4{RST_D}};
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tcnt_q   <= tcnt_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    assign thousands  = frame_q[3];
    assign hundreds   = frame_q[2];
    assign tens       = frame_q[1];
    assign units      = frame_q[0];
    assign frame_done = done_q;
    assign err        = err_q;
    assign err_code   = code_q;

endmodule

// File: tb/tb_bcd_frame_loader.sv
// Testbench for bcd_frame_loader: scoreboard of expected committed frames,
// popped and compared whenever frame_done is seen.
module tb_bcd_frame_loader;

    localparam int         TMO   = 16;
    localparam logic [3:0] RST_D = 4'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_digit = 4'd0;
    logic       in_sof = 1'b0;
    logic       in_ready;
    logic       err_clr = 1'b0;
    logic [3:0] thousands, hundreds, tens, units;
    logic       frame_done;
    logic       err;
    logic [1:0] err_code;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_out = {4{RST_D}};
    logic [15:0] outs;

    assign outs = {thousands, hundreds, tens, units};

    bcd_frame_loader #(.TIMEOUT_CYCLES(TMO), .RESET_DIGIT(RST_D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_digit(in_digit),
        .in_sof(in_sof), .in_ready(in_ready), .err_clr(err_clr),
        .thousands(thousands), .hundreds(hundreds), .tens(tens), .units(units),
        .frame_done(frame_done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] model(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] c, input logic [3:0] d);
        logic [15:0] r;
        r = {a, b, c, d};
`ifdef BCD_LEADING_ZERO_BLANK_EN
        if (a == 4'd0) begin
            r[15:12] = 4'hF;
            if (b == 4'd0) begin
                r[11:8] = 4'hF;
                if (c == 4'd0) r[7:4] = 4'hF;
            end
        end
`endif
        return r;
    endfunction

    // Scoreboard consumer: every frame_done must match the oldest queued frame.
    always @(negedge clk) begin
        if (frame_done) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: got frame %h, want no frame_done", outs);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                if (outs !== e) begin
                    n_fail++;
                    $display("FAIL sb_frame: got %h want %h", outs, e);
                end
                exp_out = e;
            end
        end
    end

    task automatic send(input logic sof, input logic [3:0] d);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_sof = sof; in_digit = d;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: in_ready stayed %b, want 1", in_ready);
        end
        @(posedge clk);
    endtask

    task automatic clear_err;
        @(negedge clk); err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
    endtask

    task automatic test_reset;
        n_chk++; if (outs !== {4{RST_D}}) begin n_fail++; $display("FAIL reset_outs: got %h want %h", outs, {4{RST_D}}); end
        n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", frame_done); end
        n_chk++; if (err !== 1'b0 || err_code !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b/%b want 0/00", err, err_code); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic_frame;
        logic [15:0] e;
        e = model(4'd1, 4'd2, 4'd3, 4'd4);
        sb.push_back(e);
        send(1'b1, 4'd1); send(1'b0, 4'd2); send(1'b0, 4'd3); send(1'b0, 4'd4);
        #1;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL commit_ready: got %b want 0", in_ready); end
        n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL commit_early_done: got %b want 0", frame_done); end
        n_chk++; if (outs !== exp_out) begin n_fail++; $display("FAIL commit_early_outs: got %h want %h", outs, exp_out); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_chk++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got %b want 1", frame_done); end
        n_chk++; if (outs !== e) begin n_fail++; $display("FAIL basic_outs: got %h want %h", outs, e); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_commit_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b want 0", frame_done); end
    endtask

    task automatic test_idle_drop;
        send(1'b0, 4'd7); send(1'b0, 4'd8);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_chk++; if (outs !== exp_out) begin n_fail++; $display("FAIL idle_drop_outs: got %h want %h", outs, exp_out); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL idle_drop_err: got %b want 0", err); end
    endtask

    task automatic test_bad_digit;
        send(1'b1, 4'd5); send(1'b0, 4'd6); send(1'b0, 4'hA);
        #1 in_valid = 1'b0;
        n_chk++; if (err !== 1'b1 || err_code !== 2'b01) begin n_fail++; $display("FAIL bad_digit_err: got %b/%b want 1/01", err, err_code); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL error_ready: got %b want 0", in_ready); end
        repeat (3) @(posedge clk); #1;
        n_chk++; if (err !== 1'b1 || outs !== exp_out) begin n_fail++; $display("FAIL error_hold: got err %b outs %h want 1 %h", err, outs, exp_out); end
        clear_err;
        n_chk++; if (err !== 1'b0 || err_code !== 2'b00 || in_ready !== 1'b1) begin n_fail++; $display("FAIL err_clr: got %b/%b rdy %b want 0/00 rdy 1", err, err_code, in_ready); end
        sb.push_back(model(4'd9, 4'd8, 4'd7, 4'd6));
        send(1'b1, 4'd9); send(1'b0, 4'd8); send(1'b0, 4'd7); send(1'b0, 4'd6);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        n_chk++; if (outs !== model(4'd9, 4'd8, 4'd7, 4'd6)) begin n_fail++; $display("FAIL recover_outs: got %h want %h", outs, model(4'd9, 4'd8, 4'd7, 4'd6)); end
        send(1'b1, 4'd2); send(1'b1, 4'hC);
        #1 in_valid = 1'b0;
        n_chk++; if (err_code !== 2'b01) begin n_fail++; $display("FAIL code_priority: got %b want 01", err_code); end
        clear_err;
        send(1'b1, 4'hF);
        #1 in_valid = 1'b0;
        n_chk++; if (err !== 1'b1 || err_code !== 2'b01) begin n_fail++; $display("FAIL idle_bad_sof: got %b/%b want 1/01", err, err_code); end
        clear_err;
    endtask

    task automatic test_timeout;
        send(1'b1, 4'd3);
        #1 in_valid = 1'b0;
        repeat (TMO - 1) @(posedge clk); #1;
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got err %b want 0", err); end
        @(posedge clk); #1;
        n_chk++; if (err !== 1'b1 || err_code !== 2'b10) begin n_fail++; $display("FAIL timeout_code: got %b/%b want 1/10", err, err_code); end
        n_chk++; if (outs !== exp_out) begin n_fail++; $display("FAIL timeout_outs: got %h want %h", outs, exp_out); end
        clear_err;
        sb.push_back(model(4'd2, 4'd0, 4'd5, 4'd9));
        send(1'b1, 4'd2);
        #1 in_valid = 1'b0;
        repeat (12) @(posedge clk);
        send(1'b0, 4'd0);
        #1 in_valid = 1'b0;
        repeat (12) @(posedge clk);
        send(1'b0, 4'd5); send(1'b0, 4'd9);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_chk++; if (err !== 1'b0 || outs !== model(4'd2, 4'd0, 4'd5, 4'd9)) begin n_fail++; $display("FAIL timer_restart: got err %b outs %h want 0 %h", err, outs, model(4'd2, 4'd0, 4'd5, 4'd9)); end
    endtask

    task automatic test_sof_mid_and_reset;
        send(1'b1, 4'd1); send(1'b0, 4'd2); send(1'b1, 4'd4);
        #1 in_valid = 1'b0;
        n_chk++; if (err !== 1'b1 || err_code !== 2'b11) begin n_fail++; $display("FAIL sof_mid_code: got %b/%b want 1/11", err, err_code); end
        n_chk++; if (outs !== exp_out) begin n_fail++; $display("FAIL sof_mid_outs: got %h want %h", outs, exp_out); end
        clear_err;
        send(1'b1, 4'd1); send(1'b0, 4'd2);
        #1 in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_out = {4{RST_D}};
        n_chk++; if (outs !== {4{RST_D}}) begin n_fail++; $display("FAIL midreset_outs: got %h want %h", outs, {4{RST_D}}); end
        n_chk++; if (in_ready !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL midreset_state: got rdy %b err %b want 1 0", in_ready, err); end
        send(1'b0, 4'd6);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        n_chk++; if (outs !== {4{RST_D}}) begin n_fail++; $display("FAIL midreset_idle: got %h want %h", outs, {4{RST_D}}); end
    endtask

    task automatic test_back_to_back;
        int t0, t1;
        sb.push_back(model(4'd0, 4'd0, 4'd4, 4'd2));
        sb.push_back(model(4'd0, 4'd0, 4'd0, 4'd0));
        send(1'b1, 4'd0);
        #1 t0 = cyc;
        send(1'b0, 4'd0); send(1'b0, 4'd4); send(1'b0, 4'd2);
        send(1'b1, 4'd0); send(1'b0, 4'd0); send(1'b0, 4'd0); send(1'b0, 4'd0);
        #1 t1 = cyc;
        in_valid = 1'b0;
        n_chk++; if (t1 - t0 !== 8) begin n_fail++; $display("FAIL b2b_rate: got %0d cycles want 8", t1 - t0); end
        sb.push_back(model(4'd0, 4'd1, 4'd0, 4'd0));
        send(1'b1, 4'd0); send(1'b0, 4'd1); send(1'b0, 4'd0); send(1'b0, 4'd0);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_chk++; if (outs !== model(4'd0, 4'd1, 4'd0, 4'd0)) begin n_fail++; $display("FAIL blank_outs: got %h want %h", outs, model(4'd0, 4'd1, 4'd0, 4'd0)); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset;
        test_basic_frame;
        test_idle_drop;
        test_bad_digit;
        test_timeout;
        test_sof_mid_and_reset;
        test_back_to_back;
        repeat (3) @(posedge clk); #1;
        n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d frames pending want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
